demod_pipe_ctrl: RTL

DEMOD_PIPE_CTRL -- requirements
Module: demod_pipe_ctrl

---
 rtl/demod_pkg.sv | 12 +
 rtl/demod_valid_track.sv | 41 ++++
 rtl/demod_pipe_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/demod_pkg.sv
// Shared constants for the demod pipeline controller: mode encodings, default
// geometry and the latency limit the controller is built for.
package demod_pkg;
  localparam int DEMOD_MODE_STREAM  = 0;
  localparam int DEMOD_MODE_ONESHOT = 1;

  localparam int DEF_SEG_W   = 32;
  localparam int DEF_NUM_SEG = 10;
  localparam int DEF_LATENCY = 14;

  localparam int MAX_LATENCY = 64;
endpackage

// File: rtl/demod_valid_track.sv
// Token shift register shadowing the datapath stages, plus a running count of
// tokens in flight including the one parked in the output register.
module demod_valid_track #(
  parameter int LATENCY = 14,
  parameter int CNT_W   = $clog2(LATENCY + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             ins,
  input  logic             drain,
  input  logic             clr,
  output logic             exit_tok,
  output logic [CNT_W-1:0] count
);
  logic [LATENCY-1:0] tok;

  assign exit_tok = adv && tok[LATENCY-1];

  if (LATENCY == 1) begin : g_one
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)   tok <= '0;
      else if (clr) tok <= '0;
      else if (adv) tok <= ins;
    end
  end else begin : g_shift
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)   tok <= '0;
      else if (clr) tok <= '0;
      else if (adv) tok <= {tok[LATENCY-2:0], ins};
    end
  end

  // A token moving into the output register does not change the total, so
  // only new accepts and consumer pops move the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   count <= '0;
    else if (clr) count <= '0;
    else          count <= count + CNT_W'(ins) - CNT_W'(drain);
  end
endmodule

// File: rtl/demod_pipe_ctrl.sv
// Valid/ready control around an external fixed-latency demod datapath: elastic
// streaming with a one-entry output holding register, or a legacy one-shot counter.
module demod_pipe_ctrl
  import demod_pkg::*;
#(
  parameter int SEG_W   = DEF_SEG_W,
  parameter int NUM_SEG = DEF_NUM_SEG,
  parameter int LATENCY = DEF_LATENCY,
  parameter int MODE    = DEMOD_MODE_STREAM
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_SEG*SEG_W-1:0]     seg_in,
  input  logic                         flush,
  output logic                         pipe_en,
  output logic [NUM_SEG*SEG_W-1:0]     pipe_seg,
  input  logic [SEG_W-1:0]             pipe_dout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEG_W-1:0]             out_data,
  output logic                         busy,
  output logic [$clog2(LATENCY+2)-1:0] inflight
);
  localparam int IW      = $clog2(LATENCY + 2);
  localparam int CW      = $clog2(LATENCY + 1);
  localparam bit ONESHOT = (MODE == DEMOD_MODE_ONESHOT);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("demod_pipe_ctrl: LATENCY %0d outside 1..%0d", LATENCY, MAX_LATENCY);
  end

  logic          ov_q;
  logic [SEG_W-1:0] dat_q;
  logic [CW-1:0] cnt_q;
  logic          st_en, accept, drain, tok_exit;
  logic [IW-1:0] tok_cnt;

  // Whole pipe advances only when the holding register can take a result.
  assign st_en    = !ov_q || out_ready;
  assign accept   = in_valid && st_en && !flush;
  assign drain    = ov_q && out_ready;
  assign pipe_seg = seg_in;

  demod_valid_track #(.LATENCY(LATENCY), .CNT_W(IW)) u_track (
    .clk      (clk),
    .reset    (reset),
    .adv      (st_en),
    .ins      (accept),
    .drain    (drain),
    .clr      (flush || ONESHOT),
    .exit_tok (tok_exit),
    .count    (tok_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ov_q  <= 1'b0;
      dat_q <= '0;
    end else if (flush) begin
      ov_q  <= 1'b0;
    end else if (tok_exit) begin
      ov_q  <= 1'b1;
      dat_q <= pipe_dout;
    end else if (drain) begin
      ov_q  <= 1'b0;
    end
  end

  // One-shot: length of the current in_valid run, capped at LATENCY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    cnt_q <= '0;
    else if (flush || !in_valid)   cnt_q <= '0;
    else if (cnt_q != CW'(LATENCY)) cnt_q <= cnt_q + CW'(1);
  end

  always_comb begin
    pipe_en   = st_en;
    in_ready  = st_en && !flush;
    out_valid = ov_q;
    out_data  = dat_q;
    busy      = (tok_cnt != '0);
    inflight  = tok_cnt;
    if (ONESHOT) begin
      pipe_en   = 1'b1;
      in_ready  = 1'b1;
      out_valid = (cnt_q == CW'(LATENCY));
      out_data  = pipe_dout;
      busy      = (cnt_q != CW'(LATENCY));
      inflight  = IW'(cnt_q);
    end
  end
endmodule
